// File: rtl/ip_codma_bus_arbiter.sv
// ip_codma_bus_arbiter: fair one-owner arbiter for the shared codma memory bus, with a dead cycle between owners.
// Define CODMA_ARB_TIMEOUT_EN to revoke a grant held for TENURE_MAX cycles while the other engine waits.
module ip_codma_bus_arbiter #(
    parameter int TENURE_MAX = 64,
    parameter int CNT_W      = $clog2(TENURE_MAX + 1)
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rd_req_i,
    input  logic       rd_done_i,
    input  logic       wr_req_i,
    input  logic       wr_done_i,
    output logic       rd_gnt_o,
    output logic       wr_gnt_o,
    output logic [1:0] bus_owner_o,
    output logic       timeout_o
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_RD, ARB_WR, ARB_GAP} arb_state_t;

    arb_state_t state, state_nxt;
    logic last_wr, last_wr_nxt;
    logic owned, own_done, own_req, revoke;

    assign owned    = (state == ARB_RD) || (state == ARB_WR);
    assign own_done = (state == ARB_RD) ? rd_done_i : wr_done_i;
    assign own_req  = (state == ARB_RD) ? rd_req_i : wr_req_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ARB_IDLE;
            last_wr <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_wr <= last_wr_nxt;
        end
    end

    // On a tie, the engine that did not own the bus last goes first.
    always_comb begin
        state_nxt   = state;
        last_wr_nxt = last_wr;
        if (!owned)
            state_nxt = (rd_req_i && (!wr_req_i || last_wr)) ? ARB_RD :
                        wr_req_i ? ARB_WR : ARB_IDLE;
        else if (own_done || !own_req || revoke) begin
            state_nxt   = ARB_GAP;
            last_wr_nxt = (state == ARB_WR);
        end
    end

`ifdef CODMA_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic other_req, entering;

    assign other_req = (state == ARB_RD) ? wr_req_i : rd_req_i;
    assign entering  = !owned && ((state_nxt == ARB_RD) || (state_nxt == ARB_WR));
    assign revoke    = owned && (cnt == CNT_W'(TENURE_MAX - 1)) && !own_done && other_req;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= revoke;
            if (entering)
                cnt <= '0;
            else if (owned && cnt != CNT_W'(TENURE_MAX))
                cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TENURE_MAX > CNT_W);
    assign revoke     = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    assign rd_gnt_o    = (state == ARB_RD);
    assign wr_gnt_o    = (state == ARB_WR);
    assign bus_owner_o = {wr_gnt_o, rd_gnt_o};
endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// tb_ip_codma_bus_arbiter: directed vectors feed an expected-output queue; a negedge monitor pops and compares.
module tb_ip_codma_bus_arbiter;
    localparam logic [4:0] E_I = 5'b00000;  // {rd_gnt, wr_gnt, bus_owner, timeout}
    localparam logic [4:0] E_R = 5'b10010;
    localparam logic [4:0] E_W = 5'b01100;
    localparam logic [4:0] E_T = 5'b00001;

    logic clk = 1'b0, reset = 1'b1;
    logic rd_req = 0, rd_done = 0, wr_req = 0, wr_done = 0;
    logic rd_gnt, wr_gnt, timeout;
    logic [1:0] bus_owner;
    int checks = 0, errors = 0, step_no = 0;

    typedef struct { logic [4:0] exp; int id; } exp_t;
    exp_t exp_q[$];

    ip_codma_bus_arbiter #(.TENURE_MAX(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .rd_req_i(rd_req), .rd_done_i(rd_done),
        .wr_req_i(wr_req), .wr_done_i(wr_done),
        .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .bus_owner_o(bus_owner), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {rd_gnt, wr_gnt, bus_owner, timeout};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (outs() !== e.exp) begin
                errors++;
                $display("FAIL step%0d: outputs %b, expected %b", e.id, outs(), e.exp);
            end
            if (rd_gnt && wr_gnt) begin
                errors++;
                $display("FAIL step%0d both_grants: rd_gnt=%b wr_gnt=%b, expected not both", e.id, rd_gnt, wr_gnt);
            end
        end
    end

    // Drive inputs for one cycle; e is the output expected after the edge samples them.
    task automatic step(input logic r, input logic w, input logic rd, input logic wd, input logic [4:0] e);
        rd_req = r; wr_req = w; rd_done = rd; wr_done = wd;
        @(posedge clk);
        #1;
        step_no++;
        exp_q.push_back('{exp: e, id: step_no});
    endtask

    task automatic direct_check(input string name, input logic [4:0] e);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL %s: outputs %b, expected %b", name, outs(), e);
        end
    endtask

    // Assert reset mid-cycle, after the monitor has sampled.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        direct_check("async_reset", E_I);
        rd_req = 0; wr_req = 0; rd_done = 0; wr_done = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_state", E_I);
        reset = 1'b0;
        // Reset mid-grant, then request to grant latency
        step(1, 0, 0, 0, E_R);
        step(1, 0, 0, 0, E_R);
        do_reset();
        step(1, 0, 0, 0, E_R);
        step(0, 0, 1, 0, E_I);
        step(0, 0, 0, 0, E_I);
        // Tie after reset and 6-transaction alternation, 3 owned cycles each
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic [4:0] own;
            own = (k % 2 == 0) ? E_R : E_W;
            step(1, 1, 0, 0, own);
            step(1, 1, 0, 0, own);
            step(1, 1, 0, 0, own);
            step(1, 1, own == E_R, own == E_W, E_I);
        end
        // Abandon write: last owner stays write so the next tie goes to read
        step(0, 1, 0, 0, E_W);
        step(0, 1, 0, 0, E_W);
        step(0, 0, 0, 0, E_I);
        step(0, 0, 0, 0, E_I);
        step(1, 1, 0, 0, E_R);
        step(1, 1, 0, 1, E_R);
        step(0, 1, 1, 0, E_I);
        step(0, 1, 0, 0, W_or_W());
        // Done together with req drop, dones ignored while unowned
        step(0, 0, 0, 1, E_I);
        step(0, 0, 1, 1, E_I);
        step(0, 0, 0, 0, E_I);
        // Owner re-granted after a gap with no competitor
        step(1, 0, 0, 0, E_R);
        step(1, 0, 1, 0, E_I);
        step(1, 0, 0, 0, E_R);
        step(0, 0, 0, 0, E_I);
        step(0, 0, 0, 0, E_I);
        // Long read tenure with the writer waiting
        step(1, 0, 0, 0, E_R);
`ifdef CODMA_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, E_R);
        step(1, 1, 0, 0, E_T);
        step(1, 1, 0, 0, E_W);
        step(0, 0, 0, 1, E_I);
        step(0, 0, 0, 0, E_I);
        step(1, 0, 0, 0, E_R);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, E_R);
        step(0, 0, 0, 0, E_I);
`else
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0, E_R);
        step(0, 1, 0, 0, E_I);
        step(0, 1, 0, 0, E_W);
        step(0, 0, 0, 1, E_I);
`endif
        step(0, 0, 0, 0, E_I);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [4:0] W_or_W();
        return E_W;
    endfunction
endmodule
